// File: rtl/uart_pkg.sv
// Shared command codes, configuration bit positions and transmitter state
// encoding for the command-driven UART transmitter.
package uart_pkg;

  localparam logic [1:0] CMD_DATA   = 2'd0;
  localparam logic [1:0] CMD_CONFIG = 2'd1;
  localparam logic [1:0] CMD_PREDIV = 2'd2;
  localparam logic [1:0] CMD_SPARE  = 2'd3;

  localparam logic [4:0] CMD_CONFIG_RESET = 5'b11000;

  localparam int CFG_PARITY_EN  = 0;
  localparam int CFG_PARITY_ODD = 1;
  localparam int CFG_TWO_STOP   = 2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

endpackage

// File: rtl/uart_fifo.sv
// Small synchronous FIFO with a first-word-fall-through read port, flush,
// and a registered overflow pulse for pushes that find it full.
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic             overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             overflow_reg;
  logic             push_ok;
  logic             pop_ok;

  // The extra pointer MSB tells a full FIFO apart from an empty one.
  assign empty    = (wr_ptr_reg == rd_ptr_reg);
  assign full     = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                    (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign push_ok  = push && (!full || pop);
  assign pop_ok   = pop && !empty;
  assign dout     = mem[rd_ptr_reg[AW-1:0]];
  assign overflow = overflow_reg;

  always_ff @(posedge clk) begin
    if (push_ok && !flush) begin
      mem[wr_ptr_reg[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      overflow_reg <= push && full && !pop;
    end
  end

endmodule

// File: rtl/uart_cmd_tx.sv
// UART transmitter fed by a 2-bit command / 5-bit argument port: nibble-wise
// data staging, FIFO queueing, programmable prescaler and frame format.
module uart_cmd_tx
  import uart_pkg::*;
#(
  parameter int               DATA_W     = 8,
  parameter int               DIV_W      = 12,
  parameter logic [DIV_W-1:0] DIV_RESET  = 12'd3,
  parameter int               FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  input  logic [1:0] cmd,
  input  logic [4:0] arg,
  output logic       tx,
  output logic       busy,
  output logic       fifo_full,
  output logic       fifo_empty,
  output logic       overflow,
  output logic       soft_reset_strobe
);

  localparam int BIT_W = $clog2(DATA_W);

  logic [DATA_W-5:0] staging_reg;
  logic [2:0]        cfg_reg;
  logic [DIV_W-1:0]  div_shadow_reg;
  logic [DIV_W-1:0]  div_active_reg;
  logic              soft_reset_strobe_reg;

  tx_state_t         state_reg;
  logic              tx_reg;
  logic              busy_reg;
  logic [DIV_W-1:0]  cnt_reg;
  logic [DIV_W-1:0]  frame_div_reg;
  logic              frame_parity_en_reg;
  logic              frame_two_stop_reg;
  logic              stop_idx_reg;
  logic              parity_reg;
  logic [BIT_W-1:0]  bit_idx_reg;
  logic [DATA_W-1:0] shift_reg;

  logic              data_cmd;
  logic              prediv_cmd;
  logic              cfg_wr;
  logic              soft_rst;
  logic              push;
  logic              pop_req;
  logic              last_stop;
  logic [DATA_W-1:0] push_word;
  logic [DATA_W-1:0] fifo_dout;
  logic [DIV_W-1:0]  div_next;

  assign data_cmd   = cmd_valid && (cmd == CMD_DATA);
  assign prediv_cmd = cmd_valid && (cmd == CMD_PREDIV);
  assign soft_rst   = cmd_valid && (cmd == CMD_CONFIG) && (arg == CMD_CONFIG_RESET);
  assign cfg_wr     = cmd_valid && (cmd == CMD_CONFIG) && (arg[4:3] == 2'b00);
  assign push       = data_cmd && arg[4];
  assign push_word  = {arg[3:0], staging_reg};
  assign div_next   = (div_shadow_reg << 4) | DIV_W'(arg[3:0]);
  assign last_stop  = !frame_two_stop_reg || stop_idx_reg;

  // A new frame starts from IDLE or straight out of the final stop bit;
  // a coincident soft reset suppresses the pop.
  assign pop_req = !fifo_empty && !soft_rst &&
                   ((state_reg == IDLE) ||
                    ((state_reg == STOP) && (cnt_reg == '0) && last_stop));

  uart_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pop      (pop_req),
    .flush    (soft_rst),
    .din      (push_word),
    .dout     (fifo_dout),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .overflow (overflow)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      staging_reg           <= '0;
      cfg_reg               <= '0;
      div_shadow_reg        <= DIV_RESET;
      div_active_reg        <= DIV_RESET;
      soft_reset_strobe_reg <= 1'b0;
    end else begin
      soft_reset_strobe_reg <= soft_rst;
      if (soft_rst) begin
        staging_reg <= '0;
      end else if (data_cmd) begin
        staging_reg <= arg[4] ? '0 : push_word[DATA_W-1:4];
      end
      if (cfg_wr) cfg_reg <= arg[2:0];
      if (prediv_cmd) begin
        div_shadow_reg <= div_next;
        if (arg[4]) div_active_reg <= div_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg           <= IDLE;
      tx_reg              <= 1'b1;
      busy_reg            <= 1'b0;
      cnt_reg             <= '0;
      frame_div_reg       <= '0;
      frame_parity_en_reg <= 1'b0;
      frame_two_stop_reg  <= 1'b0;
      stop_idx_reg        <= 1'b0;
      parity_reg          <= 1'b0;
      bit_idx_reg         <= '0;
      shift_reg           <= '0;
    end else if (soft_rst) begin
      state_reg <= IDLE;
      tx_reg    <= 1'b1;
      busy_reg  <= 1'b0;
    end else if (pop_req) begin
      // Frame parameters are frozen here so mid-frame writes only affect the next frame.
      state_reg           <= START;
      tx_reg              <= 1'b0;
      busy_reg            <= 1'b1;
      cnt_reg             <= div_active_reg;
      frame_div_reg       <= div_active_reg;
      frame_parity_en_reg <= cfg_reg[CFG_PARITY_EN];
      frame_two_stop_reg  <= cfg_reg[CFG_TWO_STOP];
      parity_reg          <= (^fifo_dout) ^ cfg_reg[CFG_PARITY_ODD];
      shift_reg           <= fifo_dout;
    end else if (state_reg != IDLE) begin
      if (cnt_reg != '0) begin
        cnt_reg <= cnt_reg - 1'b1;
      end else begin
        cnt_reg <= frame_div_reg;
        case (state_reg)
          START: begin
            state_reg   <= DATA;
            tx_reg      <= shift_reg[0];
            shift_reg   <= shift_reg >> 1;
            bit_idx_reg <= '0;
          end
          DATA: begin
            if (bit_idx_reg == BIT_W'(DATA_W - 1)) begin
              stop_idx_reg <= 1'b0;
              if (frame_parity_en_reg) begin
                state_reg <= PARITY;
                tx_reg    <= parity_reg;
              end else begin
                state_reg <= STOP;
                tx_reg    <= 1'b1;
              end
            end else begin
              tx_reg      <= shift_reg[0];
              shift_reg   <= shift_reg >> 1;
              bit_idx_reg <= bit_idx_reg + 1'b1;
            end
          end
          PARITY: begin
            state_reg    <= STOP;
            tx_reg       <= 1'b1;
            stop_idx_reg <= 1'b0;
          end
          STOP: begin
            if (!last_stop) begin
              stop_idx_reg <= 1'b1;
            end else begin
              state_reg <= IDLE;
              tx_reg    <= 1'b1;
              busy_reg  <= 1'b0;
            end
          end
          default: begin
            state_reg <= IDLE;
            tx_reg    <= 1'b1;
            busy_reg  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign tx                = tx_reg;
  assign busy              = busy_reg;
  assign soft_reset_strobe = soft_reset_strobe_reg;

endmodule
